key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Converts PS/2 scancode bytes from the keyboard receiver into the shared 4-bit game key codes (A, S, W, D, 1–4, Esc).
- Tracks which keys are held and buffers press/release events in a parametrised FIFO with a valid/ready handshake.
- Sits between the PS/2 receiver and the game/menu control logic.
- It is the event-driven successor to the single "current key" scheme: it adds multi-key hold state, repeat suppression and buffering.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.
- NUM_KEYS, 9: number of mapped keys; key code k (1..NUM_KEYS) maps to held_keys[k-1].
- SUPPRESS_REPEAT, 1: 1 = a make code for an already-held key generates no event; 0 = every make generates a press event.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sc_valid  in  1  one-cycle strobe; sc_data is valid this cycle
- sc_data  in  8  PS/2 scancode byte
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts the head event
- evt_code  out  4  head event key code
- evt_pressed  out  1  head event type: 1 = press, 0 = release
- key_code  out  4  most recently pressed key still held, else key_relesed (4'b0000)
- held_keys  out  NUM_KEYS  one bit per held key
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset (asynchronous assert, synchronous release): parser to IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_pressed=0, key_code=key_relesed, held_keys=0, overflow=0.
- Parser FSM; it advances only on sc_valid.
  - IDLE: 8'hF0 -> BRK; 8'hE0 -> EXT; any other byte is decoded as a make.
  - BRK: any byte is decoded as a break -> IDLE.
  - EXT: 8'hF0 -> EXT_BRK; any other byte is discarded -> IDLE.
  - EXT_BRK: any byte is discarded -> IDLE. Extended keys are not mapped.
- Mapping: 1C=A, 1B=S, 1D=W, 23=D, 16=1, 1E=2, 26=3, 25=4, 76=Esc, giving the package key codes 1..9. Unmapped bytes produce no event and change no state, but the FSM still returns to IDLE.
- Make of mapped key k:
  - Sets held bit k-1 and sets key_code=k.
  - Pushes {k, press}, unless SUPPRESS_REPEAT=1 and the bit was already set. In that case there is no push, but key_code is still updated to k.
- Break of mapped key k:
  - Clears held bit k-1 and pushes {k, release}.
  - If key_code==k, key_code becomes key_relesed, even if other keys are still held.
  - A break for a key that is not held still pushes a release event.
- Latency: an event decoded from a byte with sc_valid at cycle N is visible at the FIFO head by cycle N+1 if the FIFO was empty. held_keys and key_code also update at N+1.
- FIFO behaviour:
  - Pop occurs when evt_valid && evt_ready.
  - The head outputs come straight from storage and are stable while evt_valid=1 and evt_ready=0.
  - Push and pop in the same cycle is allowed at any occupancy, including full: the push succeeds and occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are determined by a count register 0..FIFO_DEPTH.
- Overflow:
  - A push while full with no pop drops the new event and sets overflow.
  - Held/key_code state still updates for a dropped event.
  - clr_overflow clears the flag; if a drop occurs in the same cycle, overflow remains set.
- At most one byte per cycle. sc_valid on consecutive cycles must be handled.

Decomposition:
- Add to the shared package:
  - Scancode constants (SC_A, SC_S, …, SC_BREAK=8'hF0, SC_EXT=8'hE0).
  - Parser state enum typedef.
  - A key-event struct typedef {logic [3:0] code; logic pressed;}.
- Reuse the existing key_* codes.
- One sub-module: key_event_fifo, a generic synchronous FIFO parametrised by DEPTH and data width, with count, full and empty.

Test Plan:
- Bytes 1C, F0, 1C -> events {1,press} then {1,release}; key_code goes 1 then 0; held_keys[0] goes 1 then 0.
- SUPPRESS_REPEAT=1, bytes 1D, 1D, 1D -> a single {3,press} event; held_keys[2]=1. Rerun with SUPPRESS_REPEAT=0 -> three press events.
- Bytes 1C, 23, F0 1C -> key_code=4 (D) after 23, still 4 after the A break; held_keys=9'b000001000.
- Bytes E0 1C, E0 F0 1C, 0x5A -> no events; held_keys unchanged; FSM back in IDLE.
- evt_ready=0, 9 key presses with FIFO_DEPTH=8 -> 8 events stored, overflow=1. Drain all 8 in order; clr_overflow then clears the flag.
- FIFO full, a push and evt_ready=1 in the same cycle -> head pops, new event is stored, no overflow. Then assert rst_n low mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared key codes, PS/2 scancode constants and types for the keyboard event path.
package key_event_queue_pkg;

   localparam logic [3:0] key_relesed = 4'd0;
   localparam logic [3:0] key_a       = 4'd1;
   localparam logic [3:0] key_s       = 4'd2;
   localparam logic [3:0] key_w       = 4'd3;
   localparam logic [3:0] key_d       = 4'd4;
   localparam logic [3:0] key_1       = 4'd5;
   localparam logic [3:0] key_2       = 4'd6;
   localparam logic [3:0] key_3       = 4'd7;
   localparam logic [3:0] key_4       = 4'd8;
   localparam logic [3:0] key_esc     = 4'd9;

   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } parse_state_t;

   typedef struct packed {
      logic [3:0] code;
      logic       pressed;
   } key_event_t;

   // Unmapped scancodes return key_relesed, which callers treat as "no key".
   function automatic logic [3:0] map_scancode(input logic [7:0] sc);
      case (sc)
         SC_A:    map_scancode = key_a;
         SC_S:    map_scancode = key_s;
         SC_W:    map_scancode = key_w;
         SC_D:    map_scancode = key_d;
         SC_1:    map_scancode = key_1;
         SC_2:    map_scancode = key_2;
         SC_3:    map_scancode = key_3;
         SC_4:    map_scancode = key_4;
         SC_ESC:  map_scancode = key_esc;
         default: map_scancode = key_relesed;
      endcase
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Generic synchronous FIFO; the head entry is read straight from storage.
module key_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_ONE;
         end else if (!do_push && do_pop) begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/key_event_queue.sv
// PS/2 scancode parser that tracks held keys and queues press/release events for the game logic.
module key_event_queue
   import key_event_queue_pkg::*;
#(
   parameter int FIFO_DEPTH      = 8,
   parameter int NUM_KEYS        = 9,
   parameter int SUPPRESS_REPEAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sc_valid,
   input  logic [7:0]          sc_data,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [3:0]          evt_code,
   output logic                evt_pressed,
   output logic [3:0]          key_code,
   output logic [NUM_KEYS-1:0] held_keys,
   output logic                overflow,
   input  logic                clr_overflow
);

   localparam logic [3:0]          MAX_CODE = 4'(NUM_KEYS);
   localparam logic [NUM_KEYS-1:0] ONE_MASK = NUM_KEYS'(1);

   parse_state_t        state;
   logic [1:0]          rst_pipe;
   logic                rst_int_n;
   logic [3:0]          byte_code;
   logic                valid_key;
   logic [NUM_KEYS-1:0] key_mask;
   logic                already_held;
   logic                is_make;
   logic                is_break;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   key_event_t          push_evt;
   key_event_t          head_evt;

   // Reset asserts immediately but is released only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end
   assign rst_int_n = rst_pipe[1];

   always_comb begin
      byte_code    = map_scancode(sc_data);
      valid_key    = (byte_code != key_relesed) && (byte_code <= MAX_CODE);
      key_mask     = ONE_MASK << (byte_code - 4'd1);
      already_held = |(held_keys & key_mask);
      is_make      = sc_valid && (state == ST_IDLE) && (sc_data != SC_BREAK)
                     && (sc_data != SC_EXT) && valid_key;
      is_break     = sc_valid && (state == ST_BRK) && valid_key;
      push         = is_break || (is_make && !((SUPPRESS_REPEAT != 0) && already_held));
      push_evt.code    = byte_code;
      push_evt.pressed = is_make;
   end

   assign evt_valid   = !fifo_empty;
   assign pop         = evt_valid && evt_ready;
   assign evt_code    = head_evt.code;
   assign evt_pressed = head_evt.pressed;

   // Parser, hold tracking and overflow share one registered block so they move together.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state     <= ST_IDLE;
         key_code  <= key_relesed;
         held_keys <= '0;
         overflow  <= 1'b0;
      end else begin
         if (sc_valid) begin
            case (state)
               ST_IDLE: begin
                  if (sc_data == SC_BREAK) begin
                     state <= ST_BRK;
                  end else if (sc_data == SC_EXT) begin
                     state <= ST_EXT;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_EXT:  state <= (sc_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
         if (is_make) begin
            held_keys <= held_keys | key_mask;
            key_code  <= byte_code;
         end else if (is_break) begin
            held_keys <= held_keys & ~key_mask;
            if (key_code == byte_code) begin
               key_code <= key_relesed;
            end
         end
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(key_event_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_int_n),
      .push      (push),
      .push_data (push_evt),
      .pop       (pop),
      .pop_data  (head_evt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue; a second instance runs with repeat suppression disabled.
module tb_key_event_queue;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sc_valid = 1'b0;
   logic [7:0] sc_data = 8'h00;
   logic       evt_ready = 1'b0;
   logic       clr_overflow = 1'b0;

   logic       evt_valid, evt_pressed, overflow;
   logic [3:0] evt_code, key_code;
   logic [8:0] held_keys;

   logic       nr_evt_valid, nr_evt_pressed, nr_overflow;
   logic [3:0] nr_evt_code, nr_key_code;
   logic [8:0] nr_held_keys;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] sc_list [9] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};

   always #5 clk = ~clk;

   key_event_queue #(.FIFO_DEPTH(8), .NUM_KEYS(9), .SUPPRESS_REPEAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .sc_valid(sc_valid), .sc_data(sc_data),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_pressed(evt_pressed), .key_code(key_code), .held_keys(held_keys),
      .overflow(overflow), .clr_overflow(clr_overflow)
   );

   key_event_queue #(.FIFO_DEPTH(8), .NUM_KEYS(9), .SUPPRESS_REPEAT(0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .sc_valid(sc_valid), .sc_data(sc_data),
      .evt_valid(nr_evt_valid), .evt_ready(evt_ready), .evt_code(nr_evt_code),
      .evt_pressed(nr_evt_pressed), .key_code(nr_key_code), .held_keys(nr_held_keys),
      .overflow(nr_overflow), .clr_overflow(clr_overflow)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; back-to-back calls give consecutive sc_valid cycles.
   task automatic send_byte(input logic [7:0] b);
      sc_valid = 1'b1;
      sc_data  = b;
      @(negedge clk);
      sc_valid = 1'b0;
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic expect_head(input string tag, input logic [3:0] code, input logic pressed);
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_code"}, 32'(evt_code), 32'(code));
      check({tag, "_pressed"}, 32'(evt_pressed), 32'(pressed));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      do_reset();
      check("rst_evt_valid", 32'(evt_valid), 32'd0);
      check("rst_evt_code", 32'(evt_code), 32'd0);
      check("rst_evt_pressed", 32'(evt_pressed), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_held", 32'(held_keys), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // A press then release of A, visible one cycle after each byte.
      send_byte(8'h1C);
      expect_head("a_make", 4'd1, 1'b1);
      check("a_make_key_code", 32'(key_code), 32'd1);
      check("a_make_held", 32'(held_keys), 32'h001);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check("a_brk_key_code", 32'(key_code), 32'd0);
      check("a_brk_held", 32'(held_keys), 32'h000);
      expect_head("a_ev0", 4'd1, 1'b1);
      pop_one();
      expect_head("a_ev1", 4'd1, 1'b0);
      pop_one();
      check("a_drained", 32'(evt_valid), 32'd0);

      // Repeated makes of W: one event with suppression, three without.
      do_reset();
      send_byte(8'h1D);
      send_byte(8'h1D);
      send_byte(8'h1D);
      check("w_held", 32'(held_keys), 32'h004);
      check("w_key_code", 32'(key_code), 32'd3);
      expect_head("w_ev", 4'd3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("nr_valid", 32'(nr_evt_valid), 32'd1);
         check("nr_code", 32'(nr_evt_code), 32'd3);
         check("nr_pressed", 32'(nr_evt_pressed), 32'd1);
         pop_one();
         if (i == 0) check("w_single", 32'(evt_valid), 32'd0);
      end
      check("nr_drained", 32'(nr_evt_valid), 32'd0);

      // key_code follows the latest press and survives a break of another key.
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h23);
      check("ad_key_code", 32'(key_code), 32'd4);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check("ad_brk_key_code", 32'(key_code), 32'd4);
      check("ad_held", 32'(held_keys), 32'h008);
      expect_head("ad_ev0", 4'd1, 1'b1);
      pop_one();
      expect_head("ad_ev1", 4'd4, 1'b1);
      pop_one();
      expect_head("ad_ev2", 4'd1, 1'b0);
      pop_one();
      check("ad_drained", 32'(evt_valid), 32'd0);

      // Extended and unmapped bytes are ignored; a following S proves the parser is idle.
      send_byte(8'hE0);
      send_byte(8'h1C);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      send_byte(8'h5A);
      check("ext_no_evt", 32'(evt_valid), 32'd0);
      check("ext_held", 32'(held_keys), 32'h008);
      check("ext_key_code", 32'(key_code), 32'd4);
      send_byte(8'h1B);
      expect_head("ext_idle", 4'd2, 1'b1);
      check("ext_idle_held", 32'(held_keys), 32'h00A);
      pop_one();

      // Nine presses into an eight-deep FIFO: the Esc press is dropped.
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(sc_list[i]);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_held", 32'(held_keys), 32'h1FF);
      check("ovf_key_code", 32'(key_code), 32'd9);
      for (int i = 0; i < 8; i++) begin
         expect_head("ovf_drain", 4'(i + 1), 1'b1);
         pop_one();
      end
      check("ovf_empty", 32'(evt_valid), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Fill with eight releases, then push and pop together while full.
      for (int i = 0; i < 8; i++) begin
         send_byte(8'hF0);
         send_byte(sc_list[i]);
      end
      check("full_held", 32'(held_keys), 32'h100);
      check("full_no_ovf", 32'(overflow), 32'd0);
      expect_head("full_head", 4'd1, 1'b0);
      send_byte(8'hF0);
      evt_ready = 1'b1;
      send_byte(8'h76);
      evt_ready = 1'b0;
      check("pp_no_ovf", 32'(overflow), 32'd0);
      check("pp_key_code", 32'(key_code), 32'd0);
      check("pp_held", 32'(held_keys), 32'h000);
      expect_head("pp_head", 4'd2, 1'b0);
      send_byte(8'h1C);
      check("drop_ovf", 32'(overflow), 32'd1);
      check("drop_held", 32'(held_keys), 32'h001);
      check("drop_key_code", 32'(key_code), 32'd1);
      expect_head("drop_head_stable", 4'd2, 1'b0);

      // Asynchronous reset between clock edges clears everything at once.
      #2 rst_n = 1'b0;
      #1;
      check("arst_evt_valid", 32'(evt_valid), 32'd0);
      check("arst_evt_code", 32'(evt_code), 32'd0);
      check("arst_evt_pressed", 32'(evt_pressed), 32'd0);
      check("arst_key_code", 32'(key_code), 32'd0);
      check("arst_held", 32'(held_keys), 32'd0);
      check("arst_overflow", 32'(overflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
